alu_result_accumulator: RTL
===========================

# alu_result_accumulator

Downstream stage for the 16-bit signed ALU: consumes one ALU result per valid/ready handshake and accumulates a batch of COUNT results. It presents the batch sum, minimum, maximum and a saturation flag through an output valid/ready handshake. It turns the combinational ALU output into registered, batched statistics for the next stage.

## Interface
- DATA_W, 16, width of signed ALU result input
- ACC_W, 20, width of signed accumulated sum (ACC_W >= DATA_W)
- COUNT, 4, results per batch (>= 1); counter width $clog2(COUNT)+1
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous abort: discard partial batch/held result
- in_valid  input  1  in_data holds a valid ALU result
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  DATA_W  signed ALU result
- out_valid  output  1  batch result available
- out_ready  input  1  downstream accepts result this cycle
- out_sum  output  ACC_W  signed saturated batch sum
- out_min  output  DATA_W  signed minimum of batch
- out_max  output  DATA_W  signed maximum of batch
- out_sat  output  1  sum saturated at least once in batch

## Operation
- Clock is clk, reset is rst_n: one clock, asynchronous active-low reset.
- States: ACCUM and HOLD.
- ACCUM: in_ready=1, out_valid=0. Each accept (in_valid & in_ready) does the following:
  - sum += sign-extended in_data, saturating at ±(2^(ACC_W-1)) limits (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)).
  - Any clamp sets sticky sat.
  - First accept of a batch loads min=max=in_data and sum=in_data; later accepts compare signed.
  - count increments.
- Accept with count==COUNT-1: the final sum/min/max/sat are copied to the out_* registers. Next state is HOLD and the internal accumulators zero.
- HOLD: in_ready=0, out_valid=1, out_* stable. When out_ready=1 the handshake completes at the edge and the next state is ACCUM.
- in_valid low in ACCUM: no change (gaps allowed).
- clear=1 has priority over every other event:
  - next state ACCUM, count/sum/sat zeroed, out_valid=0, out_* zeroed.
  - Any accept or output handshake in that cycle is discarded.
- Reset (rst_n=0, any time including mid-batch or in HOLD):
  - state ACCUM, count=0.
  - out_valid=0, out_sum=0, out_min=0, out_max=0, out_sat=0.
  - in_ready=1 (decoded from state).
- in_ready and out_valid are decoded from state only; there are no combinational paths from in_valid or out_ready.

## Timing
- in_ready and out_valid are Moore outputs; out_* are registered.
- Latency: final sample accepted at edge k means out_valid=1 from edge k to the completing handshake edge.
- Throughput: COUNT accept cycles plus at least 1 HOLD cycle per batch, i.e. one bubble when out_ready is held high.
- Back-pressure: out_ready low holds HOLD indefinitely, in_ready=0, out_* unchanged.
- COUNT=1: every accept goes directly to HOLD; out_min=out_max=in_data, out_sum=in_data.

## Test plan
- Basic batch, defaults, in_data sequence -6, 15, 35, -20 on consecutive cycles, out_ready=1 -> out_valid for 1 cycle with out_sum=24, out_min=-20, out_max=35, out_sat=0; in_ready low exactly that cycle.
- Saturation, ACC_W=17, four samples 32767 -> out_sum=65535, out_sat=1. Follow with batch -32768 x4 -> out_sum=-65536, out_sat=1. Then batch 1,1,1,1 -> out_sum=4, out_sat=0 (sticky cleared per batch).
- Back-pressure: complete a batch, hold out_ready=0 for 5 cycles with in_valid=1 and in_data toggling -> in_ready=0 and out_* constant all 5 cycles. Release -> ACCUM next cycle and the next batch starts from count 0.
- Gapped input: samples 100, -100, 7, 7 with in_valid low 2 cycles between each -> out_sum=14, out_min=-100, out_max=100.
- clear mid-batch: after 2 accepts assert clear 1 cycle with in_valid=1 -> that sample is dropped; the next 4 samples 1,2,3,4 give out_sum=10, min=1, max=4. Also assert clear in HOLD -> out_valid drops next cycle and out_* read 0.
- Async reset: drop rst_n mid-batch between clock edges -> out_valid, out_* go 0 immediately and in_ready=1. After release, a fresh batch 5,5,5,5 -> out_sum=20.

Source files
------------

// File: rtl/alu_result_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_accumulator
// Brief    : Batches COUNT signed ALU results into saturated sum, min, max and
//            sticky saturation flag, presented through a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_accumulator #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 20,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic              out_sat
);

    localparam int CNT_W = $clog2(COUNT) + 1;
    localparam logic [CNT_W-1:0]        C_LAST    = CNT_W'(COUNT - 1);
    localparam logic signed [ACC_W-1:0] C_SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]         r_count;
    logic signed [ACC_W-1:0]  r_sum;
    logic signed [DATA_W-1:0] r_min;
    logic signed [DATA_W-1:0] r_max;
    logic                     r_sat;

    logic [ACC_W-1:0]  r_out_sum;
    logic [DATA_W-1:0] r_out_min;
    logic [DATA_W-1:0] r_out_max;
    logic              r_out_sat;

    logic                     w_accept;
    logic                     w_first;
    logic                     w_last;
    logic signed [DATA_W-1:0] w_din;
    logic signed [ACC_W-1:0]  w_ext;
    logic signed [ACC_W-1:0]  w_base;
    logic signed [ACC_W:0]    w_wide;
    logic                     w_ovf;
    logic signed [ACC_W-1:0]  w_sum_nxt;
    logic                     w_sat_nxt;
    logic signed [DATA_W-1:0] w_min_nxt;
    logic signed [DATA_W-1:0] w_max_nxt;

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_HOLD);

    assign w_accept = in_ready & in_valid;
    assign w_first  = (r_count == '0);
    assign w_last   = (r_count == C_LAST);
    assign w_din    = $signed(in_data);
    assign w_ext    = ACC_W'(w_din);

    // One guard bit above the accumulator exposes signed overflow for clamping.
    assign w_base    = w_first ? '0 : r_sum;
    assign w_wide    = (ACC_W+1)'(w_base) + (ACC_W+1)'(w_ext);
    assign w_ovf     = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    assign w_sum_nxt = !w_ovf ? w_wide[ACC_W-1:0]
                              : (w_wide[ACC_W] ? C_SUM_MIN : C_SUM_MAX);
    assign w_sat_nxt = (!w_first & r_sat) | w_ovf;
    assign w_min_nxt = (w_first || (w_din < r_min)) ? w_din : r_min;
    assign w_max_nxt = (w_first || (w_din > r_max)) ? w_din : r_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_HOLD;
                ST_HOLD:  if (out_ready)          w_state_nxt = ST_ACCUM;
                default:  w_state_nxt = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_sum     <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_sat     <= 1'b0;
            r_out_sum <= '0;
            r_out_min <= '0;
            r_out_max <= '0;
            r_out_sat <= 1'b0;
        end else if (clear) begin
            r_count   <= '0;
            r_sum     <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_sat     <= 1'b0;
            r_out_sum <= '0;
            r_out_min <= '0;
            r_out_max <= '0;
            r_out_sat <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_out_sum <= w_sum_nxt;
                r_out_min <= w_min_nxt;
                r_out_max <= w_max_nxt;
                r_out_sat <= w_sat_nxt;
                r_count   <= '0;
                r_sum     <= '0;
                r_min     <= '0;
                r_max     <= '0;
                r_sat     <= 1'b0;
            end else begin
                r_count <= r_count + CNT_W'(1);
                r_sum   <= w_sum_nxt;
                r_min   <= w_min_nxt;
                r_max   <= w_max_nxt;
                r_sat   <= w_sat_nxt;
            end
        end
    end

    assign out_sum = r_out_sum;
    assign out_min = r_out_min;
    assign out_max = r_out_max;
    assign out_sat = r_out_sat;

endmodule
`default_nettype wire
